serial_bits_eq: RTL
===================

SERIAL_BITS_EQ -- requirements
Module: serial_bits_eq

Interface
REQ-001 SHALL have parameter WIDTH, default 3, operand width in bits, legal range 1..64.
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port ASYNCRESETN  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port I0  input  WIDTH  operand A, sampled on accept.
REQ-005 SHALL have port I1  input  WIDTH  operand B, sampled on accept.
REQ-006 SHALL have port I_valid  input  1  operand pair valid.
REQ-007 SHALL have port I_ready  output  1  block can accept an operand pair.
REQ-008 SHALL have port O  output  1  result: 1 = I0 equals I1.
REQ-009 SHALL have port O_idx  output  max(1,$clog2(WIDTH))  index of the lowest mismatching bit; 0 when O=1.
REQ-010 SHALL have port O_valid  output  1  result valid.
REQ-011 SHALL have port O_ready  input  1  consumer takes the result.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 SHALL drive I_ready=1 only in IDLE; an accept is I_valid&&I_ready.
REQ-014 SHALL, on accept, latch I0/I1 into shift registers, clear the bit counter, set an internal eq flag to 1, and go to SHIFT.
REQ-015 SHALL, in SHIFT, compare one bit pair per cycle, LSB first, at counter positions 0..WIDTH-1.
REQ-016 SHALL, on the first mismatch, clear the eq flag and record the counter value as O_idx; later mismatches SHALL NOT change O_idx.
REQ-017 SHALL leave SHIFT for DONE after the bit at position WIDTH-1 is compared; without early exit, O_valid rises exactly WIDTH+1 cycles after the accept edge.
REQ-018 SHALL, in DONE, hold O_valid=1 and keep O and O_idx stable until O_ready=1.
REQ-019 SHALL, in DONE with O_ready=1, go to IDLE on that edge; the next accept occurs at the earliest one cycle later.
REQ-020 SHALL ignore I_valid and input changes outside IDLE.
REQ-021 SHALL keep the counter wide enough that WIDTH-1 does not wrap, including WIDTH=1 (one SHIFT cycle).

Reset
REQ-022 SHALL, while ASYNCRESETN=0, immediately force state IDLE, counter 0, eq flag 0, shift registers 0, O=0, O_idx=0, O_valid=0, and I_ready=0.
REQ-023 SHALL drive I_ready=1 in the first cycle after ASYNCRESETN is released.
REQ-024 SHALL discard any in-flight comparison when reset is asserted mid-SHIFT or mid-DONE; no result is produced for it.

Configuration
REQ-025 SHALL, with SERIAL_BITS_EQ_EARLY_EXIT_EN defined, go from SHIFT to DONE on the edge that detects the first mismatch; for a mismatch at index k, O_valid rises k+2 cycles after the accept edge.
REQ-026 SHALL, without SERIAL_BITS_EQ_EARLY_EXIT_EN, always spend WIDTH cycles in SHIFT, giving fixed latency.

Structure
REQ-027 SHALL place the FSM state enum (IDLE/SHIFT/DONE) and a function for the index width, max(1,$clog2(WIDTH)), in the shared package serial_bits_eq_pkg.
REQ-028 SHALL contain exactly one sub-module, serial_bits_eq_shreg: a WIDTH-bit load/shift-right register with asynchronous active-low clear, instantiated once for each operand.

Verification
REQ-029 SHALL cover: WIDTH=3, I0=3'b101, I1=3'b101, O_ready=1 -> O=1, O_idx=0, O_valid 4 cycles after accept, for one cycle.
REQ-030 SHALL cover: WIDTH=3, I0=3'b101, I1=3'b100 -> O=0, O_idx=0; O_valid 2 cycles after accept with SERIAL_BITS_EQ_EARLY_EXIT_EN defined, 4 cycles after accept without it.
REQ-031 SHALL cover: I0=3'b011, I1=3'b111, O_ready=0 for 5 cycles -> O=0, O_idx=2; O, O_idx and O_valid held stable; I_ready=0 until the cycle after O_ready=1.
REQ-032 SHALL cover: ASYNCRESETN pulsed low during the 2nd SHIFT cycle -> O_valid=0 immediately; I_ready=1 the cycle after release; no stale result appears.
REQ-033 SHALL cover: I_valid held high with changing I0 while in SHIFT -> result reflects only the operands latched at accept.
REQ-034 SHALL cover: WIDTH=1, I0=1, I1=0 -> O=0, O_idx=0, O_valid 2 cycles after accept.

Source files
------------

// File: rtl/serial_bits_eq_pkg.sv
// serial_bits_eq_pkg: shared FSM state type and index-width helper
// for the serial_bits_eq comparator.
package serial_bits_eq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int idx_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_bits_eq_shreg.sv
// serial_bits_eq_shreg: WIDTH-bit load / shift-right register,
// async active-low clear; lsb is the bit currently presented.
module serial_bits_eq_shreg #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             lsb
);

  logic [WIDTH-1:0] r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
    end else if (load) begin
      r <= d;
    end else if (shift) begin
      r <= r >> 1;
    end
  end

  assign lsb = r[0];

endmodule

// File: rtl/serial_bits_eq.sv
// serial_bits_eq: bit-serial equality compare, LSB first, valid/ready.
// Define SERIAL_BITS_EQ_EARLY_EXIT_EN to finish on the first mismatch.
module serial_bits_eq
  import serial_bits_eq_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic                      CLK,
  input  logic                      ASYNCRESETN,
  input  logic [WIDTH-1:0]          I0,
  input  logic [WIDTH-1:0]          I1,
  input  logic                      I_valid,
  output logic                      I_ready,
  output logic                      O,
  output logic [idx_w(WIDTH)-1:0]   O_idx,
  output logic                      O_valid,
  input  logic                      O_ready
);

  localparam int IW = idx_w(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  state_e        state;
  logic [IW-1:0] cnt;
  logic [IW-1:0] idx_q;
  logic          eq_q;
  logic          accept;
  logic          shifting;
  logic          a_bit;
  logic          b_bit;
  logic          miss;
  logic          leave;

  // Gated by reset so no accept is advertised while held in reset.
  assign I_ready  = (state == IDLE) && ASYNCRESETN;
  assign accept   = I_valid && I_ready;
  assign shifting = (state == SHIFT);
  assign miss     = a_bit ^ b_bit;

`ifdef SERIAL_BITS_EQ_EARLY_EXIT_EN
  assign leave = (cnt == LAST) || (miss && eq_q);
`else
  assign leave = (cnt == LAST);
`endif

  serial_bits_eq_shreg #(.WIDTH(WIDTH)) u_sh_a (
    .clk   (CLK),
    .rst_n (ASYNCRESETN),
    .load  (accept),
    .shift (shifting),
    .d     (I0),
    .lsb   (a_bit)
  );

  serial_bits_eq_shreg #(.WIDTH(WIDTH)) u_sh_b (
    .clk   (CLK),
    .rst_n (ASYNCRESETN),
    .load  (accept),
    .shift (shifting),
    .d     (I1),
    .lsb   (b_bit)
  );

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state <= IDLE;
      cnt   <= '0;
      eq_q  <= 1'b0;
      idx_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state <= SHIFT;
            cnt   <= '0;
            eq_q  <= 1'b1;
            idx_q <= '0;
          end
        end
        SHIFT: begin
          if (miss && eq_q) begin
            eq_q  <= 1'b0;
            idx_q <= cnt;
          end
          if (leave) begin
            state <= DONE;
          end else begin
            cnt <= cnt + IW'(1);
          end
        end
        DONE: begin
          if (O_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign O_valid = (state == DONE);
  assign O       = O_valid && eq_q;
  assign O_idx   = idx_q;

endmodule
